free_list_ckpt: RTL

- Parametrised physical-register free list for the out-of-order core; next generation of the current fixed 32-entry free list.
- Circular queue of free physical register indices with two read pointers: speculative head (rename allocation) and commit head (ROB retirement).
- A pipeline flush rolls the speculative head back to the commit head in one cycle, reclaiming every register allocated by squashed instructions without walking the ROB.
- Sits between rename/dispatch (allocation), ROB commit (commit-advance and old-pd return) and the flush controller.

---
 rtl/free_list_ckpt_pkg.sv | 8 +
 rtl/free_list_ckpt.sv | 88 ++++++++
 2 files changed

// File: rtl/free_list_ckpt_pkg.sv
// Shared sizing defaults for the physical-register free list.
package free_list_ckpt_pkg;
  localparam int FREE_LIST_DEPTH      = 32;
  localparam int PHYS_REG_BITS        = 6;
  localparam int FREE_LIST_FIRST_FREE = 32;
  localparam int FREE_LIST_ADDR_WIDTH = $clog2(FREE_LIST_DEPTH);
  localparam int FREE_LIST_PTR_WIDTH  = FREE_LIST_ADDR_WIDTH + 1;
endpackage

// File: rtl/free_list_ckpt.sv
// Circular free list of physical registers with a speculative head for rename
// and a commit head for retirement; flush rolls the speculative head back.
module free_list_ckpt
  import free_list_ckpt_pkg::*;
#(
  parameter int DEPTH       = FREE_LIST_DEPTH,
  parameter int DATA_WIDTH  = PHYS_REG_BITS,
  parameter int FIRST_FREE  = FREE_LIST_FIRST_FREE,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_req,
  output logic                  alloc_ready,
  output logic [DATA_WIDTH-1:0] alloc_pd,
  input  logic                  commit_alloc,
  input  logic                  free_valid,
  input  logic [DATA_WIDTH-1:0] free_pd,
  input  logic                  flush,
  output logic [PTR_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  spec_head;
  logic [PTR_WIDTH-1:0]  commit_head;
  logic [PTR_WIDTH-1:0]  tail;
  logic [PTR_WIDTH-1:0]  commit_head_nxt;
  logic                  alloc_fire;
  logic                  free_fire;
  logic                  free_bad;
  logic                  commit_fire;
  logic                  commit_bad;

  // Show-ahead read; a same-cycle free never bypasses into alloc_pd.
  assign alloc_pd    = mem[spec_head[ADDR_WIDTH-1:0]];
  assign alloc_ready = (spec_head != tail);
  assign count       = tail - spec_head;
  assign full        = (count == PTR_WIDTH'(DEPTH));

  assign alloc_fire  = alloc_req && alloc_ready && !flush;
  assign free_fire   = free_valid && !full;
  assign free_bad    = free_valid && full;
  // A commit is legal only if something is allocated, counting this cycle's alloc.
  assign commit_fire = commit_alloc && ((commit_head != spec_head) || alloc_fire);
  assign commit_bad  = commit_alloc && !commit_fire;
  assign commit_head_nxt = commit_fire ? commit_head + PTR_WIDTH'(1) : commit_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= PTR_WIDTH'(DEPTH);
      err         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_WIDTH'(FIRST_FREE + i);
      end
    end else begin
      if (flush) begin
        spec_head <= commit_head_nxt;
      end else if (alloc_fire) begin
        spec_head <= spec_head + PTR_WIDTH'(1);
      end
      commit_head <= commit_head_nxt;
      if (free_fire) begin
        mem[tail[ADDR_WIDTH-1:0]] <= free_pd;
        tail                      <= tail + PTR_WIDTH'(1);
      end
      if (free_bad || commit_bad) begin
        err <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  logic [PTR_WIDTH-1:0] inflight_dist;
  logic [PTR_WIDTH-1:0] tail_dist;
  assign inflight_dist = spec_head - commit_head;
  assign tail_dist     = tail - commit_head;

  // Wrap-order invariant: commit_head <= spec_head <= tail.
  assert property (@(posedge clk) disable iff (!rst) inflight_dist <= tail_dist);
  cover property (@(posedge clk) disable iff (!rst) $rose(err));
`endif

endmodule
